if_fetch_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and presents the fetch address to the combinational instruction memory.
- Captures the returned word plus PC+4 into the IF/ID pipeline register.
- Handles stall (load-use hold), flush (control-hazard bubble), ID-stage jump redirect and EX-stage branch redirect.
- Keeps a fetched-instruction counter for debug.

---
 rtl/if_fetch_stage.sv | 89 ++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : MIPS instruction-fetch stage: PC register, next-PC selection,
//            IF/ID pipeline register and a fetched-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_data,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_inst;
  logic [31:0] r_ifid_pc_plus4;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_ifid_load;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_ifid_load = !flush && !stall;

  // A taken branch outranks stall so the redirect is never dropped; a jump
  // under stall is re-presented by ID once the stall lifts.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (ex_branch_taken) begin
      w_next_pc = {ex_branch_target[31:2], 2'b00};
    end else if (id_jump && !stall) begin
      w_next_pc = {id_jump_target[31:2], 2'b00};
    end else if (stall) begin
      w_next_pc = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_ifid_inst     <= NOP_WORD;
      r_ifid_pc_plus4 <= 32'd0;
      r_ifid_valid    <= 1'b0;
    end else if (w_ifid_load) begin
      r_ifid_inst     <= inst_data;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'd0;
    end else if (w_ifid_load) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign inst_addr     = r_pc;
  assign ifid_inst     = r_ifid_inst;
  assign ifid_pc_plus4 = r_ifid_pc_plus4;
  assign ifid_valid    = r_ifid_valid;
  assign fetch_count   = r_fetch_count;

endmodule
`default_nettype wire
